// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage operand forwarding / hazard interface between the ID-stage consumer and fwd_hazard_ctrl.
// master = ID stage (drives the instruction), slave = controller (returns selects and stall).
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic              pipe_adv;
  logic              flush;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  logic              stall_id;
  logic [1:0]        inflight_we;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, pipe_adv, flush,
    input  fwd_sel1, fwd_sel2, stall_id, inflight_we, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rd_we, id_is_load, pipe_adv, flush,
    output fwd_sel1, fwd_sel2, stall_id, inflight_we, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Hazard/forwarding controller: EX/MEM/WB destination tracker, per-source forward select, load-use stall.
// Build option FWD_WB_BYPASS_EN: forward WB-stage data (select 3) instead of relying on write-before-read.
module fwd_src_sel #(
  parameter int REG_AW = 5
) (
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      rs,
  input  logic                   used,
  input  logic [2:0]             stg_v,
  input  logic [2:0]             stg_we,
  input  logic [2:0]             stg_ld,
  input  logic [2:0][REG_AW-1:0] stg_rd,
  output logic [1:0]             sel,
  output logic                   load_use
);
`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] WB_SEL = 2'd3;
`else
  localparam logic [1:0] WB_SEL = 2'd0;
`endif

  logic [2:0] hit;

  for (genvar s = 0; s < 3; s++) begin : g_hit
    assign hit[s] = stg_v[s] & stg_we[s] & (stg_rd[s] != '0) & used & (stg_rd[s] == rs);
  end

  // Youngest stage wins; a load in EX has no data yet, so it stalls rather than falling through.
  always_comb begin
    sel      = 2'd0;
    load_use = 1'b0;
    if (id_valid) begin
      if (hit[0]) begin
        if (stg_ld[0]) load_use = 1'b1;
        else           sel      = 2'd1;
      end else if (hit[1]) begin
        sel = 2'd2;
      end else if (hit[2]) begin
        sel = WB_SEL;
      end
    end
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  fwd_hazard_ctrl_if.slave bus
);
  localparam int STAGES = 2;
  localparam int NUM_SRC = 2;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:0][REG_AW-1:0] rd_pipe;
  logic [STAGES:0]             we_pipe;
  logic [STAGES:0]             ld_pipe;

  logic [NUM_SRC-1:0][REG_AW-1:0] rs_vec;
  logic [NUM_SRC-1:0]             used_vec;
  logic [NUM_SRC-1:0][1:0]        sel_vec;
  logic [NUM_SRC-1:0]             lu_vec;
  logic                           stall;
  logic [STAGES:0]                vw;
  logic [CNT_W-1:0]               stall_cnt;

  assign rs_vec   = {bus.id_rs2, bus.id_rs1};
  assign used_vec = {bus.id_rs2_used, bus.id_rs1_used};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(.REG_AW(REG_AW)) u_sel (
      .id_valid (bus.id_valid),
      .rs       (rs_vec[i]),
      .used     (used_vec[i]),
      .stg_v    (vld_pipe),
      .stg_we   (we_pipe),
      .stg_ld   (ld_pipe),
      .stg_rd   (rd_pipe),
      .sel      (sel_vec[i]),
      .load_use (lu_vec[i])
    );
  end

  assign stall = bus.id_valid & (|lu_vec);

  // Killed or stalled ID instructions enter EX as bubbles.
  always_ff @(posedge clk) begin
    if (rst)               vld_pipe <= '0;
    else if (bus.pipe_adv) vld_pipe <= {vld_pipe[STAGES-1:0], bus.id_valid & ~stall & ~bus.flush};
  end

  always_ff @(posedge clk) begin
    if (bus.pipe_adv) begin
      rd_pipe <= {rd_pipe[STAGES-1:0], bus.id_rd};
      we_pipe <= {we_pipe[STAGES-1:0], bus.id_rd_we};
      ld_pipe <= {ld_pipe[STAGES-1:0], bus.id_is_load};
    end
  end

  // Counts frozen cycles too; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                        stall_cnt <= '0;
    else if (stall && ~&stall_cnt)  stall_cnt <= stall_cnt + 1'b1;
  end

  assign vw = vld_pipe & we_pipe;

  assign bus.fwd_sel1     = sel_vec[0];
  assign bus.fwd_sel2     = sel_vec[1];
  assign bus.stall_id     = stall;
  assign bus.inflight_we  = {1'b0, vw[0]} + {1'b0, vw[1]} + {1'b0, vw[2]};
  assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Table-driven bench for fwd_hazard_ctrl with a scoreboard queue and a stall-counter saturation sequence.
module tb_fwd_hazard_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] W = 2'd3;
`else
  localparam logic [1:0] W = 2'd0;
`endif

  typedef struct {
    logic          rst, vld;
    logic [AW-1:0] rs1, rs2;
    logic          u1, u2;
    logic [AW-1:0] rd;
    logic          we, ld, adv, fl;
    logic [1:0]    s1, s2;
    logic          st;
    logic [1:0]    inf;
    logic [CW-1:0] sc;
  } vec_t;

  typedef struct {
    int            row;
    logic [1:0]    s1, s2;
    logic          st;
    logic [1:0]    inf;
    logic [CW-1:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  fwd_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic v, int a, int b, logic u1, logic u2, int d,
                              logic we, logic ld, logic adv, logic fl,
                              logic [1:0] s1, logic [1:0] s2, logic st, logic [1:0] inf, int sc);
    vec_t t;
    t.rst = r;  t.vld = v;  t.rs1 = AW'(a); t.rs2 = AW'(b); t.u1 = u1; t.u2 = u2;
    t.rd  = AW'(d); t.we = we; t.ld = ld; t.adv = adv; t.fl = fl;
    t.s1 = s1; t.s2 = s2; t.st = st; t.inf = inf; t.sc = CW'(sc);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst             = t.rst;
    bus.id_valid    = t.vld;
    bus.id_rs1      = t.rs1;
    bus.id_rs2      = t.rs2;
    bus.id_rs1_used = t.u1;
    bus.id_rs2_used = t.u2;
    bus.id_rd       = t.rd;
    bus.id_rd_we    = t.we;
    bus.id_is_load  = t.ld;
    bus.pipe_adv    = t.adv;
    bus.flush       = t.fl;
  endtask

  task automatic chk(input string nm, input int row, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s row %0d: got %0d want %0d", nm, row, act, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    vec_t t;
    //          rst v rs1 rs2 u1 u2 rd we ld adv fl | s1 s2 st inf sc
    vecs.push_back(mk(1,1, 5, 5,1,1, 5,1,0,1,0, 0,0,0,0,0));  // reset, random ID
    vecs.push_back(mk(0,1, 1, 2,1,1, 5,1,0,1,0, 0,0,0,0,0));  // add x5
    vecs.push_back(mk(0,1, 5, 6,1,1, 6,1,0,1,0, 1,0,0,1,0));  // sub reads x5 from EX
    vecs.push_back(mk(0,1, 5, 5,1,1, 0,0,0,1,0, 2,2,0,2,0));  // x5 now in MEM
    vecs.push_back(mk(0,1, 5, 6,1,1, 7,1,1,1,0, W,2,0,2,0));  // x5 WB, x6 MEM; ld x7
    vecs.push_back(mk(0,1, 1, 7,1,1, 8,1,0,1,0, 0,0,1,2,0));  // load-use on rs2
    vecs.push_back(mk(0,1, 1, 7,1,1, 8,1,0,1,0, 0,2,0,1,1));  // load now in MEM
    vecs.push_back(mk(0,1, 8, 7,0,1, 0,1,0,1,0, 0,W,0,2,1));  // rs1 unused; write x0
    vecs.push_back(mk(0,1, 0, 8,1,0, 9,1,0,1,1, 0,0,0,2,1));  // read x0; rs2 unused; flush add x9
    vecs.push_back(mk(0,1, 9, 9,1,1, 3,1,0,1,0, 0,0,0,2,1));  // x9 was flushed
    vecs.push_back(mk(0,1, 1, 2,1,1, 3,1,0,1,0, 0,0,0,2,1));
    vecs.push_back(mk(0,1, 1, 2,1,1, 3,1,0,1,0, 0,0,0,2,1));
    vecs.push_back(mk(0,1, 3, 3,1,1, 0,0,0,1,0, 1,1,0,3,1));  // x3 in EX/MEM/WB: EX wins
    vecs.push_back(mk(0,0, 3, 3,1,1, 0,0,0,0,0, 0,0,0,2,1));  // id_valid=0
    vecs.push_back(mk(0,1, 3, 0,1,0, 4,1,1,1,0, 2,0,0,2,1));  // ld x4
    vecs.push_back(mk(0,1, 4, 3,1,1,11,1,0,0,0, 0,W,1,2,1));  // load-use, frozen
    vecs.push_back(mk(0,1, 4, 3,1,1,11,1,0,0,0, 0,W,1,2,2));
    vecs.push_back(mk(0,1, 4, 3,1,1,11,1,0,0,0, 0,W,1,2,3));
    vecs.push_back(mk(0,1, 4, 3,1,1,11,1,0,1,0, 0,W,1,2,4));  // advance with stall
    vecs.push_back(mk(0,1, 4, 3,1,1,11,1,0,1,0, 2,0,0,1,5));
    vecs.push_back(mk(1,1,11, 4,1,1, 0,0,0,1,0, 1,W,0,2,5));  // reset mid-operation
    vecs.push_back(mk(0,1,11, 4,1,1, 0,0,0,1,0, 0,0,0,0,0));  // no stale forward

    // first reset cycle: state unknown before it, so nothing is checked
    @(negedge clk);
    drive(mk(1,1,7,3,1,1,7,1,1,1,0, 0,0,0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      e.row = i; e.s1 = vecs[i].s1; e.s2 = vecs[i].s2; e.st = vecs[i].st;
      e.inf = vecs[i].inf; e.sc = vecs[i].sc;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      chk("fwd_sel1",     e.row, int'(bus.fwd_sel1),     int'(e.s1));
      chk("fwd_sel2",     e.row, int'(bus.fwd_sel2),     int'(e.s2));
      chk("stall_id",     e.row, int'(bus.stall_id),     int'(e.st));
      chk("inflight_we",  e.row, int'(bus.inflight_we),  int'(e.inf));
      chk("stall_cycles", e.row, int'(bus.stall_cycles), int'(e.sc));
    end

    // Saturation: ld x7 then a consumer frozen for 20 cycles; 4-bit counter must stop at 15.
    @(negedge clk);
    drive(mk(0,1,1,2,1,1,7,1,1,1,0, 0,0,0,0,0));
    t = mk(0,1,7,2,1,0,12,1,0,0,0, 0,0,0,0,0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(t);
    end
    #2;
    chk("sat_stall", 100, int'(bus.stall_id), 1);
    chk("sat_cnt",   100, int'(bus.stall_cycles), 15);
    @(negedge clk);
    t.adv = 1'b1;
    drive(t);
    @(negedge clk);
    drive(t);
    #2;
    chk("sat_hold",  101, int'(bus.stall_cycles), 15);
    chk("sat_sel1",  101, int'(bus.fwd_sel1), 2);
    chk("sat_nostl", 101, int'(bus.stall_id), 0);

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d leftover want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
